quotient_guard: RTL and testbench

// Far end of the Schmidl-Cox divider path. Taps the raw divisor stream upstream of the divisor-substitution stage and records a
// per-sample zero flag and tlast in a FIFO. Realigns those flags with the quotient stream coming out of the divider IP.

---
 rtl/schmidl_cox_pkg.sv | 17 +
 rtl/axis_skid_buffer.sv | 68 ++++++
 rtl/quotient_guard.sv | 144 ++++++++++++++
 tb/tb_quotient_guard.sv | 591 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/schmidl_cox_pkg.sv
// Shared types for the Schmidl-Cox divider path.
// A divisor flag travels through the guard FIFO alongside the divider IP latency.
package schmidl_cox_pkg;

    typedef struct packed {
        logic zero;
        logic tlast;
    } div_flag_t;

    function automatic div_flag_t make_div_flag(input logic is_zero, input logic last);
        div_flag_t flag;
        flag.zero  = is_zero;
        flag.tlast = last;
        return flag;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer with registered outputs and a registered ready.
// Accepts one beat per cycle while downstream keeps up; ready drops only with both entries held.
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_fire;
    logic             out_fire;

    assign s_tready = ~skid_valid_q;
    assign m_tdata  = main_data_q;
    assign m_tvalid = main_valid_q;

    assign in_fire  = s_tvalid & s_tready;
    assign out_fire = main_valid_q & m_tready;

    // The skid entry always drains into the main entry before new input is taken there.
    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_data_d  = s_tdata;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_data_d  = s_tdata;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule

// File: rtl/quotient_guard.sv
// Records a zero/tlast flag per raw divisor and realigns it with the divider IP quotient stream.
// Quotients of a zero divisor are replaced by ZERO_VALUE and tagged; misalignment raises sticky errors.
module quotient_guard
    import schmidl_cox_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 64,
    parameter logic [WIDTH-1:0] ZERO_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [WIDTH-1:0]        s_div_tdata,
    input  logic                    s_div_tlast,
    input  logic                    s_div_tvalid,
    output logic                    s_div_tready,
    output logic [WIDTH-1:0]        m_div_tdata,
    output logic                    m_div_tlast,
    output logic                    m_div_tvalid,
    input  logic                    m_div_tready,
    input  logic [WIDTH-1:0]        s_q_tdata,
    input  logic                    s_q_tlast,
    input  logic                    s_q_tvalid,
    output logic                    s_q_tready,
    output logic [WIDTH-1:0]        m_q_tdata,
    output logic                    m_q_tlast,
    output logic                    m_q_tuser,
    output logic                    m_q_tvalid,
    input  logic                    m_q_tready,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_underflow,
    output logic                    err_tlast
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    div_flag_t        flag_mem_q [DEPTH];
    div_flag_t        push_flag_d;
    div_flag_t        head_flag;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;
    logic             err_underflow_q, err_underflow_d;
    logic             err_tlast_q, err_tlast_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             q_fire;
    logic             pop;
    logic             force_zero;
    logic [WIDTH+1:0] skid_in;
    logic [WIDTH+1:0] skid_out;

    assign full  = (occupancy_q == OCC_W'(DEPTH));
    assign empty = (occupancy_q == '0);

    // Divisor path is a pure pass-through gated only by our own FIFO level.
    assign m_div_tdata  = s_div_tdata;
    assign m_div_tlast  = s_div_tlast;
    assign m_div_tvalid = s_div_tvalid & ~full;
    assign s_div_tready = m_div_tready & ~full;

    assign push        = s_div_tvalid & s_div_tready;
    assign push_flag_d = make_div_flag(s_div_tdata == '0, s_div_tlast);

    assign q_fire    = s_q_tvalid & s_q_tready;
    assign pop       = q_fire & ~empty;
    assign head_flag = flag_mem_q[rd_ptr_q];

    // An empty FIFO yields no flag, so an orphan quotient passes untouched.
    assign force_zero = pop & head_flag.zero;
    assign skid_in    = {force_zero, s_q_tlast, force_zero ? ZERO_VALUE : s_q_tdata};

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occupancy_d     = occupancy_q;
        err_underflow_d = err_underflow_q;
        err_tlast_d     = err_tlast_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   occupancy_d = occupancy_q + OCC_W'(1);
            2'b01:   occupancy_d = occupancy_q - OCC_W'(1);
            default: occupancy_d = occupancy_q;
        endcase
        if (q_fire && empty) begin
            err_underflow_d = 1'b1;
        end
        if (pop && (s_q_tlast != head_flag.tlast)) begin
            err_tlast_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occupancy_q     <= '0;
            err_underflow_q <= 1'b0;
            err_tlast_q     <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occupancy_q     <= occupancy_d;
            err_underflow_q <= err_underflow_d;
            err_tlast_q     <= err_tlast_d;
        end
    end

    // Storage needs no reset: entries are only read between matching pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            flag_mem_q[wr_ptr_q] <= push_flag_d;
        end
    end

    axis_skid_buffer #(
        .WIDTH(WIDTH + 2)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .s_tdata  (skid_in),
        .s_tvalid (s_q_tvalid),
        .s_tready (s_q_tready),
        .m_tdata  (skid_out),
        .m_tvalid (m_q_tvalid),
        .m_tready (m_q_tready)
    );

    assign {m_q_tuser, m_q_tlast, m_q_tdata} = skid_out;

    assign occupancy     = occupancy_q;
    assign err_underflow = err_underflow_q;
    assign err_tlast     = err_tlast_q;

endmodule

// File: tb/tb_quotient_guard.sv
// Self-checking bench for quotient_guard: directed scenarios plus a randomized run
// against a queue-based reference of divisor flags and pending output beats.
module tb_quotient_guard;

    localparam int               WIDTH = 32;
    localparam int               DEPTH = 16;
    localparam int               OCC_W = $clog2(DEPTH) + 1;
    localparam logic [WIDTH-1:0] ZV    = 32'hFFFF_0000;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             user;
        logic             last;
    } out_t;

    typedef struct packed {
        logic zero;
        logic last;
    } mflag_t;

    logic             clk;
    logic             reset;
    logic             clear;
    logic [WIDTH-1:0] s_div_tdata;
    logic             s_div_tlast;
    logic             s_div_tvalid;
    logic             s_div_tready;
    logic [WIDTH-1:0] m_div_tdata;
    logic             m_div_tlast;
    logic             m_div_tvalid;
    logic             m_div_tready;
    logic [WIDTH-1:0] s_q_tdata;
    logic             s_q_tlast;
    logic             s_q_tvalid;
    logic             s_q_tready;
    logic [WIDTH-1:0] m_q_tdata;
    logic             m_q_tlast;
    logic             m_q_tuser;
    logic             m_q_tvalid;
    logic             m_q_tready;
    logic [OCC_W-1:0] occupancy;
    logic             err_underflow;
    logic             err_tlast;

    quotient_guard #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ZERO_VALUE (ZV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .s_div_tdata   (s_div_tdata),
        .s_div_tlast   (s_div_tlast),
        .s_div_tvalid  (s_div_tvalid),
        .s_div_tready  (s_div_tready),
        .m_div_tdata   (m_div_tdata),
        .m_div_tlast   (m_div_tlast),
        .m_div_tvalid  (m_div_tvalid),
        .m_div_tready  (m_div_tready),
        .s_q_tdata     (s_q_tdata),
        .s_q_tlast     (s_q_tlast),
        .s_q_tvalid    (s_q_tvalid),
        .s_q_tready    (s_q_tready),
        .m_q_tdata     (m_q_tdata),
        .m_q_tlast     (m_q_tlast),
        .m_q_tuser     (m_q_tuser),
        .m_q_tvalid    (m_q_tvalid),
        .m_q_tready    (m_q_tready),
        .occupancy     (occupancy),
        .err_underflow (err_underflow),
        .err_tlast     (err_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: flags of accepted divisors, beats accepted but not yet delivered.
    mflag_t flag_q[$];
    out_t   exp_q[$];
    logic   m_err_uf;
    logic   m_err_tl;

    int n_checks;
    int n_errors;

    logic             obs_s_div_tready;
    logic             obs_m_div_tvalid;
    logic [WIDTH-1:0] obs_m_div_tdata;
    logic             obs_m_div_tlast;
    logic             obs_s_q_tready;
    logic             obs_m_q_tvalid;
    out_t             obs_out;
    logic [OCC_W-1:0] obs_occ;
    logic             obs_err_uf;
    logic             obs_err_tl;
    int               pre_occ;
    int               pre_pending;
    logic             pre_err_uf;
    logic             pre_err_tl;
    logic             out_fired;
    logic             q_fired;
    out_t             exp_out;
    mflag_t           mf;
    out_t             mo;

    // Advance one clock: sample DUT mid-cycle, evolve the reference, return just after the edge.
    task automatic step();
        @(negedge clk);
        obs_s_div_tready = s_div_tready;
        obs_m_div_tvalid = m_div_tvalid;
        obs_m_div_tdata  = m_div_tdata;
        obs_m_div_tlast  = m_div_tlast;
        obs_s_q_tready   = s_q_tready;
        obs_m_q_tvalid   = m_q_tvalid;
        obs_out.data     = m_q_tdata;
        obs_out.user     = m_q_tuser;
        obs_out.last     = m_q_tlast;
        obs_occ          = occupancy;
        obs_err_uf       = err_underflow;
        obs_err_tl       = err_tlast;
        pre_occ          = flag_q.size();
        pre_pending      = exp_q.size();
        pre_err_uf       = m_err_uf;
        pre_err_tl       = m_err_tl;
        out_fired        = 1'b0;
        q_fired          = 1'b0;
        exp_out.data     = 'x;
        exp_out.user     = 1'bx;
        exp_out.last     = 1'bx;
        if (!reset || clear) begin
            flag_q.delete();
            exp_q.delete();
            m_err_uf = 1'b0;
            m_err_tl = 1'b0;
        end else begin
            if (obs_m_q_tvalid && m_q_tready) begin
                out_fired = 1'b1;
                if (exp_q.size() > 0) exp_out = exp_q.pop_front();
            end
            if (s_q_tvalid && obs_s_q_tready) begin
                q_fired = 1'b1;
                mo.last = s_q_tlast;
                if (flag_q.size() == 0) begin
                    m_err_uf = 1'b1;
                    mo.data  = s_q_tdata;
                    mo.user  = 1'b0;
                end else begin
                    mf      = flag_q.pop_front();
                    mo.data = mf.zero ? ZV : s_q_tdata;
                    mo.user = mf.zero;
                    if (mf.last != s_q_tlast) m_err_tl = 1'b1;
                end
                exp_q.push_back(mo);
            end
            if (s_div_tvalid && obs_s_div_tready) begin
                mf.zero = (s_div_tdata == '0);
                mf.last = s_div_tlast;
                flag_q.push_back(mf);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_div_tvalid = 1'b0;
        s_div_tdata  = '0;
        s_div_tlast  = 1'b0;
        s_q_tvalid   = 1'b0;
        s_q_tdata    = '0;
        s_q_tlast    = 1'b0;
        clear        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        m_div_tready = 1'b1;
        m_q_tready   = 1'b0;
        reset        = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        m_div_tready = 1'b1;
        m_q_tready   = 1'b0;
        s_q_tvalid   = 1'b1;
        s_q_tdata    = 32'h77;
        step();
        s_q_tvalid   = 1'b0;
        s_div_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_div_tdata = 32'(i);
            step();
        end
        idle_inputs();
        n_checks++;
        if (err_underflow !== 1'b1 || occupancy !== OCC_W'(3)) begin
            n_errors++;
            $display("[TB] FAIL pre_reset_state: got uf=%b occ=%0d expected uf=1 occ=3", err_underflow, occupancy);
        end
        do_reset();
        n_checks++;
        if (occupancy !== '0) begin
            n_errors++;
            $display("[TB] FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        n_checks++;
        if (m_q_tvalid !== 1'b0 || m_q_tdata !== '0 || m_q_tlast !== 1'b0 || m_q_tuser !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_output: got v=%b d=%h l=%b u=%b expected all zero", m_q_tvalid, m_q_tdata, m_q_tlast, m_q_tuser);
        end
        n_checks++;
        if (err_underflow !== 1'b0 || err_tlast !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL reset_errors: got uf=%b tl=%b expected 0 0", err_underflow, err_tlast);
        end
        n_checks++;
        if (s_q_tready !== 1'b1 || s_div_tready !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL reset_ready: got q=%b div=%b expected 1 1", s_q_tready, s_div_tready);
        end
    endtask

    task automatic test_packet();
        logic [WIDTH-1:0] divs   [8] = '{32'd5, 32'd0, 32'd3, 32'd0, 32'd0, 32'd7, 32'd1, 32'd9};
        logic [WIDTH-1:0] want_d [8] = '{32'd10, ZV, 32'd12, ZV, ZV, 32'd15, 32'd16, 32'd17};
        logic             want_u [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        out_t got [8];
        int   n_got;
        int   first_cyc;
        int   last_cyc;
        int   cyc;
        do_reset();
        m_q_tready   = 1'b1;
        s_div_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_div_tdata = divs[i];
            s_div_tlast = (i == 7);
            step();
        end
        idle_inputs();
        n_checks++;
        if (occupancy !== OCC_W'(8)) begin
            n_errors++;
            $display("[TB] FAIL packet_occupancy: got %0d expected 8", occupancy);
        end
        n_got     = 0;
        cyc       = 0;
        first_cyc = 0;
        last_cyc  = 0;
        for (int i = 0; i < 18; i++) begin
            if (i < 8) begin
                s_q_tvalid = 1'b1;
                s_q_tdata  = 32'(10 + i);
                s_q_tlast  = (i == 7);
            end else begin
                s_q_tvalid = 1'b0;
            end
            step();
            cyc++;
            if (out_fired && n_got < 8) begin
                if (n_got == 0) first_cyc = cyc;
                last_cyc = cyc;
                got[n_got] = obs_out;
                n_got++;
            end
        end
        n_checks++;
        if (n_got != 8) begin
            n_errors++;
            $display("[TB] FAIL packet_count: got %0d beats expected 8", n_got);
        end
        for (int k = 0; k < n_got; k++) begin
            n_checks++;
            if (got[k].data !== want_d[k] || got[k].user !== want_u[k] || got[k].last !== (k == 7)) begin
                n_errors++;
                $display("[TB] FAIL packet_beat%0d: got d=%h u=%b l=%b expected d=%h u=%b l=%b",
                         k, got[k].data, got[k].user, got[k].last, want_d[k], want_u[k], k == 7);
            end
        end
        n_checks++;
        if (last_cyc - first_cyc != 7) begin
            n_errors++;
            $display("[TB] FAIL packet_back_to_back: got span %0d cycles expected 7", last_cyc - first_cyc);
        end
        n_checks++;
        if (err_underflow !== 1'b0 || err_tlast !== 1'b0 || occupancy !== '0) begin
            n_errors++;
            $display("[TB] FAIL packet_end_state: got uf=%b tl=%b occ=%0d expected 0 0 0", err_underflow, err_tlast, occupancy);
        end
    endtask

    task automatic test_full();
        do_reset();
        m_q_tready   = 1'b0;
        s_div_tvalid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_div_tdata = 32'(i + 1);
            step();
        end
        s_div_tdata = 32'hABCD;
        step();
        n_checks++;
        if (obs_s_div_tready !== 1'b0 || obs_m_div_tvalid !== 1'b0 || obs_occ !== OCC_W'(DEPTH)) begin
            n_errors++;
            $display("[TB] FAIL full_state: got rdy=%b vld=%b occ=%0d expected 0 0 %0d",
                     obs_s_div_tready, obs_m_div_tvalid, obs_occ, DEPTH);
        end
        s_q_tvalid = 1'b1;
        s_q_tdata  = 32'd55;
        step();
        n_checks++;
        if (obs_s_div_tready !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL full_pop_cycle_ready: got %b expected 0", obs_s_div_tready);
        end
        s_q_tvalid   = 1'b0;
        s_div_tvalid = 1'b0;
        step();
        n_checks++;
        if (obs_s_div_tready !== 1'b1 || obs_occ !== OCC_W'(DEPTH - 1)) begin
            n_errors++;
            $display("[TB] FAIL full_after_pop: got rdy=%b occ=%0d expected 1 %0d", obs_s_div_tready, obs_occ, DEPTH - 1);
        end
        n_checks++;
        if (obs_m_q_tvalid !== 1'b1 || obs_out.data !== 32'd55 || obs_out.user !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL full_quotient: got v=%b d=%h u=%b expected 1 00000037 0", obs_m_q_tvalid, obs_out.data, obs_out.user);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        m_q_tready = 1'b1;
        s_q_tvalid = 1'b1;
        s_q_tdata  = 32'h1234;
        step();
        s_q_tvalid = 1'b0;
        step();
        n_checks++;
        if (obs_m_q_tvalid !== 1'b1 || obs_out.data !== 32'h1234 || obs_out.user !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL underflow_passthrough: got v=%b d=%h u=%b expected 1 00001234 0", obs_m_q_tvalid, obs_out.data, obs_out.user);
        end
        n_checks++;
        if (obs_err_uf !== 1'b1 || obs_occ !== '0 || obs_err_tl !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL underflow_flags: got uf=%b occ=%0d tl=%b expected 1 0 0", obs_err_uf, obs_occ, obs_err_tl);
        end
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (err_underflow !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL underflow_sticky: got %b expected 1", err_underflow);
        end
    endtask

    task automatic test_tlast_mismatch();
        out_t got [5];
        int   n_got;
        do_reset();
        m_q_tready   = 1'b1;
        s_div_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_div_tdata = 32'(i + 2);
            s_div_tlast = (i == 2);
            step();
        end
        idle_inputs();
        n_got = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                s_q_tvalid = 1'b1;
                s_q_tdata  = 32'(40 + i);
                s_q_tlast  = (i == 3);
            end else begin
                s_q_tvalid = 1'b0;
            end
            step();
            if (out_fired && n_got < 5) begin
                got[n_got] = obs_out;
                n_got++;
            end
            if (i < 5) begin
                n_checks++;
                if (err_tlast !== (i >= 2)) begin
                    n_errors++;
                    $display("[TB] FAIL tlast_err_after_q%0d: got %b expected %b", i, err_tlast, i >= 2);
                end
            end
        end
        n_checks++;
        if (n_got != 5) begin
            n_errors++;
            $display("[TB] FAIL tlast_count: got %0d beats expected 5", n_got);
        end
        for (int k = 0; k < n_got; k++) begin
            n_checks++;
            if (got[k].data !== 32'(40 + k) || got[k].user !== 1'b0 || got[k].last !== (k == 3)) begin
                n_errors++;
                $display("[TB] FAIL tlast_beat%0d: got d=%h u=%b l=%b expected d=%h u=0 l=%b",
                         k, got[k].data, got[k].user, got[k].last, 32'(40 + k), k == 3);
            end
        end
        n_checks++;
        if (occupancy !== '0 || err_underflow !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL tlast_consumed: got occ=%0d uf=%b expected 0 0", occupancy, err_underflow);
        end
    endtask

    task automatic test_clear();
        out_t got [2];
        int   n_got;
        do_reset();
        m_q_tready = 1'b0;
        s_q_tvalid = 1'b1;
        s_q_tdata  = 32'h99;
        step();
        s_q_tvalid   = 1'b0;
        s_div_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_div_tdata = 32'(i);
            step();
        end
        idle_inputs();
        n_checks++;
        if (occupancy !== OCC_W'(5) || m_q_tvalid !== 1'b1 || err_underflow !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL clear_setup: got occ=%0d v=%b uf=%b expected 5 1 1", occupancy, m_q_tvalid, err_underflow);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++;
        if (occupancy !== '0 || m_q_tvalid !== 1'b0 || m_q_tdata !== '0 || err_underflow !== 1'b0 || err_tlast !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL clear_state: got occ=%0d v=%b d=%h uf=%b tl=%b expected all zero",
                     occupancy, m_q_tvalid, m_q_tdata, err_underflow, err_tlast);
        end
        m_q_tready   = 1'b1;
        s_div_tvalid = 1'b1;
        s_div_tdata  = 32'd0;
        s_div_tlast  = 1'b0;
        step();
        s_div_tdata = 32'd4;
        s_div_tlast = 1'b1;
        step();
        idle_inputs();
        n_got = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                s_q_tvalid = 1'b1;
                s_q_tdata  = 32'(100 + i);
                s_q_tlast  = (i == 1);
            end else begin
                s_q_tvalid = 1'b0;
            end
            step();
            if (out_fired && n_got < 2) begin
                got[n_got] = obs_out;
                n_got++;
            end
        end
        n_checks++;
        if (n_got != 2 || got[0].data !== ZV || got[0].user !== 1'b1 || got[0].last !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL clear_realign_beat0: got n=%0d d=%h u=%b l=%b expected d=%h u=1 l=0",
                     n_got, got[0].data, got[0].user, got[0].last, ZV);
        end
        n_checks++;
        if (n_got != 2 || got[1].data !== 32'd101 || got[1].user !== 1'b0 || got[1].last !== 1'b1) begin
            n_errors++;
            $display("[TB] FAIL clear_realign_beat1: got n=%0d d=%h u=%b l=%b expected d=00000065 u=0 l=1",
                     n_got, got[1].data, got[1].user, got[1].last);
        end
        n_checks++;
        if (err_underflow !== 1'b0 || err_tlast !== 1'b0) begin
            n_errors++;
            $display("[TB] FAIL clear_realign_errors: got uf=%b tl=%b expected 0 0", err_underflow, err_tlast);
        end
    endtask

    task automatic test_random();
        int   q_acc;
        int   n_out;
        int   cyc;
        logic prev_stall;
        out_t prev_out;
        do_reset();
        q_acc      = 0;
        n_out      = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        while ((q_acc < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            s_div_tvalid = ($urandom_range(0, 3) != 0);
            s_div_tdata  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            s_div_tlast  = ($urandom_range(0, 7) == 0);
            m_div_tready = ($urandom_range(0, 3) != 0);
            s_q_tvalid   = (q_acc < 1000) && (flag_q.size() > 0) && ($urandom_range(0, 1) == 1);
            s_q_tdata    = $urandom;
            s_q_tlast    = (flag_q.size() > 0) ? flag_q[0].last : 1'b0;
            m_q_tready   = ($urandom_range(0, 1) == 1) || (q_acc >= 1000);
            step();
            cyc++;
            if (q_fired) q_acc++;
            n_checks++;
            if (obs_s_div_tready !== (m_div_tready && pre_occ < DEPTH) ||
                obs_m_div_tvalid !== (s_div_tvalid && pre_occ < DEPTH)) begin
                n_errors++;
                $display("[TB] FAIL rand_div_handshake cyc%0d: got rdy=%b vld=%b expected rdy=%b vld=%b", cyc,
                         obs_s_div_tready, obs_m_div_tvalid, m_div_tready && pre_occ < DEPTH, s_div_tvalid && pre_occ < DEPTH);
            end
            n_checks++;
            if (obs_m_div_tdata !== s_div_tdata || obs_m_div_tlast !== s_div_tlast) begin
                n_errors++;
                $display("[TB] FAIL rand_div_passthrough cyc%0d: got %h/%b expected %h/%b", cyc,
                         obs_m_div_tdata, obs_m_div_tlast, s_div_tdata, s_div_tlast);
            end
            n_checks++;
            if (obs_occ !== OCC_W'(pre_occ)) begin
                n_errors++;
                $display("[TB] FAIL rand_occupancy cyc%0d: got %0d expected %0d", cyc, obs_occ, pre_occ);
            end
            n_checks++;
            if (obs_s_q_tready !== (pre_pending < 2) || obs_m_q_tvalid !== (pre_pending > 0)) begin
                n_errors++;
                $display("[TB] FAIL rand_q_flow cyc%0d: got rdy=%b vld=%b expected rdy=%b vld=%b", cyc,
                         obs_s_q_tready, obs_m_q_tvalid, pre_pending < 2, pre_pending > 0);
            end
            if (out_fired) begin
                n_out++;
                n_checks++;
                if (obs_out !== exp_out) begin
                    n_errors++;
                    $display("[TB] FAIL rand_beat%0d: got d=%h u=%b l=%b expected d=%h u=%b l=%b", n_out,
                             obs_out.data, obs_out.user, obs_out.last, exp_out.data, exp_out.user, exp_out.last);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (obs_m_q_tvalid !== 1'b1 || obs_out !== prev_out) begin
                    n_errors++;
                    $display("[TB] FAIL rand_stall_stable cyc%0d: got v=%b d=%h expected v=1 d=%h", cyc,
                             obs_m_q_tvalid, obs_out.data, prev_out.data);
                end
            end
            prev_stall = obs_m_q_tvalid && !m_q_tready;
            prev_out   = obs_out;
            n_checks++;
            if (obs_err_uf !== pre_err_uf || obs_err_tl !== pre_err_tl || pre_err_uf || pre_err_tl) begin
                n_errors++;
                $display("[TB] FAIL rand_errors cyc%0d: got uf=%b tl=%b expected 0 0", cyc, obs_err_uf, obs_err_tl);
            end
        end
        idle_inputs();
        n_checks++;
        if (q_acc != 1000 || n_out != 1000) begin
            n_errors++;
            $display("[TB] FAIL rand_totals: got in=%0d out=%0d expected 1000 1000 within budget", q_acc, n_out);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        m_err_uf     = 1'b0;
        m_err_tl     = 1'b0;
        reset        = 1'b0;
        m_div_tready = 1'b1;
        m_q_tready   = 1'b0;
        idle_inputs();
        step();
        reset = 1'b1;
        test_reset();
        test_packet();
        test_full();
        test_underflow();
        test_tlast_mismatch();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
